// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction-fetch sequencer: PC register, imem handshake, decode hand-off
// Flush has priority over every event; drained responses are never shown to decode.
module fetch_seq #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [31:0] npc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic [1:0]  fault
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_VALID, S_DRAIN, S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic [31:0]    inst_q, inst_d;
   logic [1:0]     fault_q, fault_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           req_q, valid_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      if (flush) begin
         pc_d    = flush_pc;
         fault_d = 2'b00;
         cnt_d   = '0;
         if (flush_pc[1:0] != 2'b00) begin
            state_d = S_ERR;
            fault_d = 2'b10;
         end else begin
            // A granted or still-owed response must be swallowed before refetching.
            case (state_q)
               S_REQ:           state_d = imem_gnt ? S_DRAIN : S_REQ;
               S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
               default:         state_d = S_REQ;
            endcase
         end
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (imem_gnt) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
            end
            S_WAIT, S_DRAIN: begin
               if (imem_rvalid) begin
                  if (state_q == S_WAIT) begin
                     inst_d  = imem_rdata;
                     state_d = S_VALID;
                  end else begin
                     state_d = S_REQ;
                  end
               end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                  state_d = S_ERR;
                  fault_d = 2'b01;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_VALID: begin
               if (inst_ready) begin
                  pc_d = npc;
                  if (npc[1:0] != 2'b00) begin
                     state_d = S_ERR;
                     fault_d = 2'b10;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= 32'h0;
         fault_q <= 2'b00;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
         req_q   <= (state_d == S_REQ);
         valid_q <= (state_d == S_VALID);
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst       = inst_q;
   assign inst_valid = valid_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed and randomized checks of fetch_seq against a transaction-level model
module tb_fetch_seq;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, pc, inst;
   logic [1:0]  fault;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, inst_ready = 1'b0, flush = 1'b0;
   logic [31:0] imem_rdata = '0, npc = '0, flush_pc = '0;

   int n_chk = 0;
   int n_fail = 0;

   fetch_seq #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .pc(pc), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .npc(npc), .flush(flush), .flush_pc(flush_pc), .fault(fault)
   );

   always #5 clk = ~clk;

   // Model: described by what is outstanding and what is held, not by FSM states.
   bit          m_idle = 1, m_err = 0, m_have = 0, m_owed = 0, m_disc = 0;
   int          m_wait = 0;
   logic [31:0] m_pc = 0, m_inst = 0;
   logic [1:0]  m_fault = 0;

   function automatic bit m_req();
      return !m_idle && !m_err && !m_have && !m_owed;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_idle = 1; m_err = 0; m_have = 0; m_owed = 0; m_disc = 0;
         m_wait = 0; m_pc = 0; m_inst = 0; m_fault = 0;
      end else if (flush) begin
         if (m_req() && imem_gnt) begin m_owed = 1; m_disc = 1; end
         else if (m_owed && imem_rvalid) m_owed = 0;
         else if (m_owed) m_disc = 1;
         m_pc = flush_pc; m_fault = 0; m_have = 0; m_idle = 0; m_err = 0; m_wait = 0;
         if (flush_pc[1:0] != 0) begin m_err = 1; m_fault = 2; m_owed = 0; end
      end else if (m_idle) begin
         m_idle = 0;
      end else if (m_err) begin
      end else if (m_req()) begin
         if (imem_gnt) begin m_owed = 1; m_disc = 0; m_wait = 0; end
      end else if (m_owed) begin
         if (imem_rvalid) begin
            m_owed = 0;
            if (!m_disc) begin m_inst = imem_rdata; m_have = 1; end
         end else begin
            m_wait++;
            if (m_wait == T) begin m_err = 1; m_fault = 1; m_owed = 0; end
         end
      end else if (m_have && inst_ready) begin
         m_pc = npc; m_have = 0;
         if (npc[1:0] != 0) begin m_err = 1; m_fault = 2; end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
      if (m_req()) chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
      chk("inst", inst, m_inst);
      chk("fault", {30'b0, fault}, {30'b0, m_fault});
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   bit          pend = 0;
   int          lat = 0;

   initial begin
      // reset
      rst_n = 0; tick(); tick();
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_fault", {30'b0, fault}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", pc, 32'd0);
      rst_n = 1;

      // back-to-back fetch, 3 cycles per instruction
      for (int k = 1; k <= 9; k++) begin
         imem_gnt = 1; imem_rvalid = (k % 3 == 0); imem_rdata = 32'hA000_0000 + k;
         inst_ready = 1; npc = m_pc + 4;
         tick();
         if (k % 3 == 1) begin
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, 32'((k / 3) * 4));
         end
         if (k % 3 == 0) begin
            chk("seq_valid", {31'b0, inst_valid}, 32'd1);
            chk("seq_inst", inst, 32'hA000_0000 + k);
         end
      end

      // decode stall
      inst_ready = 0; imem_rvalid = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", {31'b0, inst_valid}, 32'd1);
         chk("stall_inst", inst, 32'hA000_0009);
         chk("stall_pc", pc, 32'd8);
         chk("stall_req", {31'b0, imem_req}, 32'd0);
      end
      inst_ready = 1; npc = 32'h40; tick();
      chk("stall_next_addr", imem_addr, 32'h40);
      chk("stall_next_req", {31'b0, imem_req}, 32'd1);

      // flush while waiting: response discarded
      inst_ready = 0; imem_gnt = 1; tick();
      imem_gnt = 0; flush = 1; flush_pc = 32'h100; tick();
      chk("drain_req", {31'b0, imem_req}, 32'd0);
      flush = 0; tick();
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick();
      chk("flush_addr", imem_addr, 32'h100);
      chk("flush_req", {31'b0, imem_req}, 32'd1);
      chk("flush_inst", inst, 32'hA000_0009);
      imem_rvalid = 0; imem_gnt = 1; tick();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_1234; tick();
      chk("after_flush_inst", inst, 32'h0000_1234);

      // bus timeout
      imem_rvalid = 0; inst_ready = 1; npc = 32'h104; tick();
      chk("to_addr", imem_addr, 32'h104);
      inst_ready = 0; imem_gnt = 1; tick();
      imem_gnt = 0;
      for (int k = 0; k < T - 1; k++) tick();
      chk("to_not_yet", {30'b0, fault}, 32'd0);
      tick();
      chk("to_fault", {30'b0, fault}, 32'd1);
      chk("to_req", {31'b0, imem_req}, 32'd0);
      imem_gnt = 1; imem_rvalid = 1; tick(); tick();
      chk("to_sticky", {30'b0, fault}, 32'd1);
      imem_gnt = 0; imem_rvalid = 0; flush = 1; flush_pc = 32'h200; tick();
      chk("to_clear", {30'b0, fault}, 32'd0);
      chk("to_resume", imem_addr, 32'h200);
      flush = 0;

      // misaligned npc, then PC wrap
      imem_gnt = 1; tick();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h13; tick();
      imem_rvalid = 0; inst_ready = 1; npc = 32'h6; tick();
      chk("mis_fault", {30'b0, fault}, 32'd2);
      chk("mis_pc", pc, 32'h6);
      inst_ready = 0; flush = 1; flush_pc = 32'hFFFF_FFFC; tick();
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      flush = 0; imem_gnt = 1; tick();
      imem_gnt = 0; imem_rvalid = 1; tick();
      imem_rvalid = 0; inst_ready = 1; npc = 32'h0; tick();
      chk("wrap_next", imem_addr, 32'h0);
      chk("wrap_req", {31'b0, imem_req}, 32'd1);
      inst_ready = 0;

      // reset mid-transaction, stray rvalid
      imem_gnt = 1; tick();
      imem_gnt = 0; rst_n = 0; tick();
      chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
      chk("mid_rst_inst", inst, 32'd0);
      rst_n = 1; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0; tick();
      chk("stray_addr", imem_addr, 32'h0);
      chk("stray_inst", inst, 32'd0);
      imem_rvalid = 0; imem_gnt = 1; tick();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h55; tick();
      chk("refetch_inst", inst, 32'h55);
      imem_rvalid = 0;

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst_n = ($urandom % 300 != 0);
         imem_rvalid = 0; imem_gnt = 0;
         if (pend) begin
            lat--;
            if (lat == 0) begin imem_rvalid = 1; imem_rdata = $urandom; pend = 0; end
         end
         if (!pend) imem_gnt = ($urandom % 3 != 0);
         flush = ($urandom % 25 == 0);
         flush_pc = $urandom;
         if ($urandom % 8 != 0) flush_pc[1:0] = 2'b00;
         inst_ready = $urandom % 2;
         npc = ($urandom % 16 == 0) ? 32'($urandom) : m_pc + 4;
         if (!rst_n) pend = 0;
         else if (m_req() && imem_gnt) begin pend = 1; lat = $urandom_range(1, 4); end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
